leaf_uplink_arbiter: RTL and testbench

Round-robin arbiter that merges the per-leaf upstream message streams into the single upstream channel of the root hub. It sits between the per-leaf delay FIFOs and the root hub core. It replaces the hub's fixed-priority leaf polling with fair, burst-limited scheduling. Every forwarded 64-bit message is tagged with the index of the leaf that supplied it.

---
 rtl/hub_pkg.sv | 15 +
 rtl/rr_pick.sv | 30 +++
 rtl/leaf_uplink_arbiter.sv | 132 +++++++++++++
 tb/tb_leaf_uplink_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hub_pkg.sv
// hub_pkg: shared types and helpers for the root hub blocks.
//   arb_state_t : upstream arbiter state (IDLE, GRANT)
//   src_w()     : width of a leaf index for a given leaf count (min 1)
package hub_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin search.
//   req   : request vector, one bit per requester
//   ptr   : index where the search starts (wraps modulo N)
//   found : at least one request is set
//   idx   : first set request at or above ptr, wrapping
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      int c;
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      if (!found && req[c]) begin
        found = 1'b1;
        idx   = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/leaf_uplink_arbiter.sv
// leaf_uplink_arbiter: merges per-leaf upstream message streams into the
// root hub's single upstream channel with burst-limited round-robin.
//   clk, reset (async, active low)
//   in_data/in_valid/in_ready : per-leaf streams, leaf i at [WIDTH*i +: WIDTH]
//   out_data/out_src/out_valid/out_ready : registered output slot + leaf tag
//   msg_count : words forwarded, saturating
module leaf_uplink_arbiter
  import hub_pkg::*;
#(
  parameter int  NUM_LEAVES = 4,
  parameter int  WIDTH      = 64,
  parameter int  MAX_BURST  = 4,
  localparam int SRC_W      = src_w(NUM_LEAVES)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [WIDTH*NUM_LEAVES-1:0] in_data,
  input  logic [NUM_LEAVES-1:0]       in_valid,
  output logic [NUM_LEAVES-1:0]       in_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [SRC_W-1:0]            out_src,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [31:0]                 msg_count
);

  localparam int BW = $clog2(MAX_BURST + 1);
  typedef logic [SRC_W-1:0] leaf_idx_t;

  arb_state_t     state_q, state_d;
  leaf_idx_t      g_q, g_d;
  leaf_idx_t      rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]  burst_cnt_q, burst_cnt_d;
  logic           out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  leaf_idx_t      out_src_q, out_src_d;
  logic [31:0]    msg_count_q, msg_count_d;

  logic           pick_found;
  leaf_idx_t      pick_idx;
  logic           slot_free;
  logic           accept;
  logic           burst_done;
  leaf_idx_t      g_inc;

  rr_pick #(.N(NUM_LEAVES), .IDX_W(SRC_W)) u_pick (
    .req   (in_valid),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Slot can take a word if empty or being drained this same cycle.
  assign slot_free  = !out_valid_q || out_ready;
  assign accept     = (state_q == GRANT) && in_valid[g_q] && slot_free;
  assign burst_done = (burst_cnt_q + BW'(1)) == BW'(MAX_BURST);
  assign g_inc      = (g_q == leaf_idx_t'(NUM_LEAVES - 1)) ? '0 : g_q + 1'b1;

  always_comb begin
    in_ready = '0;
    if (accept) in_ready[g_q] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    msg_count_d = msg_count_q;

    if (accept) begin
      out_data_d  = in_data[WIDTH*g_q +: WIDTH];
      out_src_d   = g_q;
      out_valid_d = 1'b1;
      burst_cnt_d = burst_cnt_q + BW'(1);
    end else if (slot_free) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d     = GRANT;
          g_d         = pick_idx;
          burst_cnt_d = '0;
        end
      end
      GRANT: begin
        // Backpressure alone never ends a grant: both exits need a free slot.
        if ((accept && burst_done) || (slot_free && !in_valid[g_q])) begin
          state_d  = IDLE;
          rr_ptr_d = g_inc;
        end
      end
      default: state_d = IDLE;
    endcase

    if (out_valid_q && out_ready && (msg_count_q != 32'hFFFF_FFFF))
      msg_count_d = msg_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      g_q         <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      msg_count_q <= '0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      msg_count_q <= msg_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign msg_count = msg_count_q;

endmodule

// File: tb/tb_leaf_uplink_arbiter.sv
// tb_leaf_uplink_arbiter: directed checks of the upstream arbiter with
// hand-computed expectations. Leaves are modelled as simple word queues.
module tb_leaf_uplink_arbiter;
  import hub_pkg::*;

  localparam int N = 4;
  localparam int W = 64;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [W*N-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_src;
  logic           out_valid;
  logic           out_ready;
  logic [31:0]    msg_count;

  leaf_uplink_arbiter #(.NUM_LEAVES(N), .WIDTH(W), .MAX_BURST(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .msg_count (msg_count)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] lq [N][$];
  logic [63:0] rx_data [$];
  logic [1:0]  rx_src [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      in_valid[i]     = (lq[i].size() != 0);
      in_data[W*i +: W] = (lq[i].size() != 0) ? lq[i][0] : '0;
    end
  endtask

  // One clock: leaves pop on accept, the sink records handshakes, then the
  // next cycle's inputs are driven and settled before checks.
  task automatic adv();
    logic [N-1:0] rdy;
    logic         hs;
    logic [63:0]  od;
    logic [1:0]   os;
    rdy = in_ready;
    hs  = out_valid && out_ready;
    od  = out_data;
    os  = out_src;
    @(posedge clk);
    for (int i = 0; i < N; i++)
      if (rdy[i]) void'(lq[i].pop_front());
    if (hs) begin
      rx_data.push_back(od);
      rx_src.push_back(os);
    end
    @(negedge clk);
    drive();
    #1;
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) lq[i].delete();
    rx_data.delete();
    rx_src.delete();
    out_ready = 1'b1;
    reset = 1'b0;
    drive();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  initial begin
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b1;

    // ---- reset state and single leaf ----
    do_reset();
    chk("rst_in_ready", 64'(in_ready), 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_data", out_data, 64'h0);
    chk("rst_out_src", 64'(out_src), 64'h0);
    chk("rst_msg_count", 64'(msg_count), 64'h0);
    for (int k = 0; k < 3; k++) lq[2].push_back(64'hA0 + 64'(k));
    drive(); #1;
    chk("t1_c0_rdy", 64'(in_ready), 64'h0);
    adv();
    chk("t1_c1_rdy", 64'(in_ready), 64'h4);
    chk("t1_c1_ovld", 64'(out_valid), 64'h0);
    adv();
    chk("t1_c2_ovld", 64'(out_valid), 64'h1);
    chk("t1_c2_data", out_data, 64'hA0);
    chk("t1_c2_src", 64'(out_src), 64'h2);
    adv();
    chk("t1_c3_data", out_data, 64'hA1);
    adv();
    chk("t1_c4_data", out_data, 64'hA2);
    chk("t1_c4_rdy", 64'(in_ready), 64'h0);
    adv();
    chk("t1_c5_ovld", 64'(out_valid), 64'h0);
    chk("t1_c5_state", 64'(dut.state_q), 64'(IDLE));
    chk("t1_c5_rrptr", 64'(dut.rr_ptr_q), 64'h3);
    chk("t1_c5_count", 64'(msg_count), 64'h3);

    // ---- fairness: all leaves saturated ----
    do_reset();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 8; k++) lq[i].push_back(64'h100 * 64'(i) + 64'(k));
    drive(); #1;
    for (int c = 1; c <= 21; c++) begin
      adv();
      if (c == 5)  chk("t2_bubble_rdy", 64'(in_ready), 64'h0);
      if (c == 20) chk("t2_c20_count", 64'(msg_count), 64'd15);
    end
    chk("t2_regrant0", 64'(in_ready), 64'h1);
    chk("t2_rx_n", 64'(rx_data.size()), 64'd16);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("t2_src%0d", k), 64'(rx_src[k]), 64'(k / 4));
      chk($sformatf("t2_data%0d", k), rx_data[k], 64'h100 * 64'(k / 4) + 64'(k % 4));
    end

    // ---- backpressure mid-burst ----
    do_reset();
    for (int k = 0; k < 8; k++) lq[0].push_back(64'hB0 + 64'(k));
    drive(); #1;
    adv();
    chk("t3_c1_rdy", 64'(in_ready), 64'h1);
    adv();
    chk("t3_c2_data", out_data, 64'hB0);
    for (int c = 3; c <= 7; c++) begin
      adv();
      out_ready = 1'b0;
      #1;
      chk($sformatf("t3_c%0d_ovld", c), 64'(out_valid), 64'h1);
      chk($sformatf("t3_c%0d_data", c), out_data, 64'hB1);
      chk($sformatf("t3_c%0d_rdy", c), 64'(in_ready), 64'h0);
    end
    adv();
    out_ready = 1'b1;
    #1;
    chk("t3_c8_rdy", 64'(in_ready), 64'h1);
    chk("t3_c8_data", out_data, 64'hB1);
    adv();
    chk("t3_c9_data", out_data, 64'hB2);
    chk("t3_c9_rdy", 64'(in_ready), 64'h1);
    adv();
    chk("t3_c10_data", out_data, 64'hB3);
    chk("t3_c10_rdy", 64'(in_ready), 64'h0);
    adv();
    chk("t3_rx_n", 64'(rx_data.size()), 64'd4);
    chk("t3_rx_last", rx_data[3], 64'hB3);
    chk("t3_c11_rdy", 64'(in_ready), 64'h1);

    // ---- leaf goes idle mid-burst ----
    do_reset();
    lq[1].push_back(64'hC0);
    lq[1].push_back(64'hC1);
    for (int k = 0; k < 4; k++) lq[3].push_back(64'hD0 + 64'(k));
    drive(); #1;
    adv();
    chk("t4_c1_rdy", 64'(in_ready), 64'h2);
    adv();
    chk("t4_c2_rdy", 64'(in_ready), 64'h2);
    chk("t4_c2_data", out_data, 64'hC0);
    adv();
    chk("t4_c3_rdy", 64'(in_ready), 64'h0);
    chk("t4_c3_data", out_data, 64'hC1);
    chk("t4_c3_src", 64'(out_src), 64'h1);
    adv();
    chk("t4_c4_rdy", 64'(in_ready), 64'h0);
    chk("t4_c4_ovld", 64'(out_valid), 64'h0);
    chk("t4_c4_state", 64'(dut.state_q), 64'(IDLE));
    adv();
    chk("t4_c5_rdy", 64'(in_ready), 64'h8);
    adv();
    chk("t4_c6_data", out_data, 64'hD0);
    chk("t4_c6_src", 64'(out_src), 64'h3);

    // ---- reset asserted mid-burst ----
    do_reset();
    for (int k = 0; k < 8; k++) lq[2].push_back(64'hE0 + 64'(k));
    drive(); #1;
    adv();
    adv();
    adv();
    chk("t5_pre_ovld", 64'(out_valid), 64'h1);
    for (int k = 0; k < 4; k++) lq[0].push_back(64'hF0 + 64'(k));
    drive();
    reset = 1'b0;
    #1;
    chk("t5_rst_ovld", 64'(out_valid), 64'h0);
    chk("t5_rst_rdy", 64'(in_ready), 64'h0);
    chk("t5_rst_count", 64'(msg_count), 64'h0);
    @(negedge clk);
    reset = 1'b1;
    drive(); #1;
    chk("t5_c0_rdy", 64'(in_ready), 64'h0);
    adv();
    chk("t5_c1_rdy", 64'(in_ready), 64'h1);
    adv();
    chk("t5_c2_data", out_data, 64'hF0);

    // ---- msg_count saturation ----
    do_reset();
    force dut.msg_count_q = 32'hFFFF_FFFE;
    @(posedge clk);
    @(negedge clk);
    release dut.msg_count_q;
    #1;
    chk("t6_preload", 64'(msg_count), 64'hFFFF_FFFE);
    for (int k = 0; k < 3; k++) lq[0].push_back(64'h50 + 64'(k));
    drive(); #1;
    repeat (6) adv();
    chk("t6_rx_n", 64'(rx_data.size()), 64'd3);
    chk("t6_sat", 64'(msg_count), 64'hFFFF_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
